// File: rtl/mult_div_pkg.sv
// Op encodings, FSM states and op-decode helpers shared by the
// sequential multiply/divide unit and its bench.
package mult_div_pkg;

   localparam logic [1:0] OP_MULT  = 2'b00;
   localparam logic [1:0] OP_MULTU = 2'b01;
   localparam logic [1:0] OP_DIV   = 2'b10;
   localparam logic [1:0] OP_DIVU  = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_CALC,
      ST_SIGN,
      ST_DONE
   } state_t;

   function automatic logic op_is_div(input logic [1:0] op);
      return (op == OP_DIV) || (op == OP_DIVU);
   endfunction

   function automatic logic op_is_signed(input logic [1:0] op);
      return (op == OP_MULT) || (op == OP_DIV);
   endfunction

endpackage

// File: rtl/mult_div_negate.sv
// Conditional two's-complement negate; used both to take operand
// magnitudes and to restore result signs.
module mult_div_negate #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] i_val,
   input  logic             i_neg,
   output logic [WIDTH-1:0] o_val
);

   assign o_val = i_neg ? (~i_val + WIDTH'(1)) : i_val;

endmodule

// File: rtl/mult_div_seq.sv
// Radix-2 sequential multiply/divide unit: magnitudes in, one bit per cycle
// through a 2*WIDTH accumulator, signs restored in a final SIGN step.
module mult_div_seq
   import mult_div_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             busy,
   output logic             done,
   output logic             div0
);

   localparam int CNT_W = $clog2(WIDTH) + 1;

   state_t             r_state;
   logic [CNT_W-1:0]   r_cnt;
   logic [2*WIDTH-1:0] r_acc;
   logic [WIDTH-1:0]   r_mag_b;
   logic [WIDTH-1:0]   r_hi;
   logic [WIDTH-1:0]   r_lo;
   logic               r_is_div;
   logic               r_neg_q;
   logic               r_neg_r;
   logic               r_busy;
   logic               r_done;
   logic               r_div0;

   logic               w_signed;
   logic [WIDTH-1:0]   w_mag_a;
   logic [WIDTH-1:0]   w_mag_b;
   logic [WIDTH:0]     w_sum;
   logic [WIDTH:0]     w_rsh;
   logic [WIDTH:0]     w_diff;
   logic [2*WIDTH-1:0] w_mul_next;
   logic [2*WIDTH-1:0] w_div_next;
   logic [2*WIDTH-1:0] w_prod;
   logic [WIDTH-1:0]   w_quo;
   logic [WIDTH-1:0]   w_rem;

   assign w_signed = op_is_signed(op);

   mult_div_negate #(.WIDTH(WIDTH)) u_neg_a (
      .i_val (a),
      .i_neg (w_signed & a[WIDTH-1]),
      .o_val (w_mag_a)
   );

   mult_div_negate #(.WIDTH(WIDTH)) u_neg_b (
      .i_val (b),
      .i_neg (w_signed & b[WIDTH-1]),
      .o_val (w_mag_b)
   );

   // Multiply: add b into the upper half when the LSB is set, then shift right.
   assign w_sum      = {1'b0, r_acc[2*WIDTH-1:WIDTH]}
                     + ({1'b0, r_mag_b} & {(WIDTH+1){r_acc[0]}});
   assign w_mul_next = {w_sum, r_acc[WIDTH-1:1]};

   // Divide: shift left into the remainder, keep the difference only if it did not borrow.
   assign w_rsh      = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
   assign w_diff     = w_rsh - {1'b0, r_mag_b};
   assign w_div_next = w_diff[WIDTH] ? {w_rsh[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0}
                                     : {w_diff[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};

   mult_div_negate #(.WIDTH(2*WIDTH)) u_neg_prod (
      .i_val (r_acc),
      .i_neg (r_neg_q),
      .o_val (w_prod)
   );

   mult_div_negate #(.WIDTH(WIDTH)) u_neg_quo (
      .i_val (r_acc[WIDTH-1:0]),
      .i_neg (r_neg_q),
      .o_val (w_quo)
   );

   mult_div_negate #(.WIDTH(WIDTH)) u_neg_rem (
      .i_val (r_acc[2*WIDTH-1:WIDTH]),
      .i_neg (r_neg_r),
      .o_val (w_rem)
   );

   // NOTE: state is updated with <= so every register samples pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state  <= ST_IDLE;
         r_cnt    <= '0;
         r_acc    <= '0;
         r_mag_b  <= '0;
         r_hi     <= '0;
         r_lo     <= '0;
         r_is_div <= 1'b0;
         r_neg_q  <= 1'b0;
         r_neg_r  <= 1'b0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_div0   <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_busy   <= 1'b1;
                  r_is_div <= op_is_div(op);
                  r_neg_q  <= w_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                  r_neg_r  <= w_signed & a[WIDTH-1];
                  r_mag_b  <= w_mag_b;
                  r_acc    <= {{WIDTH{1'b0}}, w_mag_a};
                  r_cnt    <= CNT_W'(WIDTH);
                  if (op_is_div(op) && (b == '0)) begin
                     r_div0  <= 1'b1;
                     r_state <= ST_DONE;
                  end else begin
                     r_div0  <= 1'b0;
                     r_state <= ST_CALC;
                  end
               end
            end
            ST_CALC: begin
               r_acc <= r_is_div ? w_div_next : w_mul_next;
               r_cnt <= r_cnt - CNT_W'(1);
               if (r_cnt == CNT_W'(1)) begin
                  r_state <= ST_SIGN;
               end
            end
            ST_SIGN: begin
               if (r_is_div) begin
                  r_hi <= w_rem;
                  r_lo <= w_quo;
               end else begin
                  {r_hi, r_lo} <= w_prod;
               end
               r_state <= ST_DONE;
            end
            ST_DONE: begin
               r_done  <= 1'b1;
               r_busy  <= 1'b0;
               r_state <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign hi   = r_hi;
   assign lo   = r_lo;
   assign busy = r_busy;
   assign done = r_done;
   assign div0 = r_div0;

endmodule

// File: tb/tb_mult_div_seq.sv
// Scoreboard bench for mult_div_seq at WIDTH=32: a behavioural model pushes
// expected hi/lo/div0/latency per command and the done pulse pops them.
module tb_mult_div_seq;
   import mult_div_pkg::*;

   localparam int W        = 32;
   localparam int LAT_NORM = W + 2;

   logic         clk;
   logic         reset;
   logic         start;
   logic [1:0]   op;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic [W-1:0] hi;
   logic [W-1:0] lo;
   logic         busy;
   logic         done;
   logic         div0;

   mult_div_seq #(.WIDTH(W)) dut (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .op    (op),
      .a     (a),
      .b     (b),
      .hi    (hi),
      .lo    (lo),
      .busy  (busy),
      .done  (done),
      .div0  (div0)
   );

   typedef struct {
      logic [W-1:0] hi;
      logic [W-1:0] lo;
      logic         div0;
      int           lat;
   } exp_t;

   typedef struct {
      logic [1:0]   op;
      logic [W-1:0] a;
      logic [W-1:0] b;
   } vec_t;

   exp_t         sb_q[$];
   vec_t         vecs[$];
   int           n_checks = 0;
   int           n_pass   = 0;
   logic [W-1:0] m_hi     = '0;
   logic [W-1:0] m_lo     = '0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", tag, got, exp);
   endtask

   function automatic exp_t model(input logic [1:0] op_i, input logic [W-1:0] a_i,
                                  input logic [W-1:0] b_i);
      exp_t        e;
      longint      sa;
      longint      sb;
      longint      q;
      longint      r;
      logic [63:0] p;
      e.lat  = LAT_NORM;
      e.div0 = 1'b0;
      if (op_i == OP_MULT) begin
         p = longint'($signed(a_i)) * longint'($signed(b_i));
         {e.hi, e.lo} = p;
      end else if (op_i == OP_MULTU) begin
         p = {{W{1'b0}}, a_i} * {{W{1'b0}}, b_i};
         {e.hi, e.lo} = p;
      end else if (b_i == '0) begin
         e.hi   = m_hi;
         e.lo   = m_lo;
         e.div0 = 1'b1;
         e.lat  = 1;
      end else begin
         if (op_i == OP_DIV) begin
            sa = longint'($signed(a_i));
            sb = longint'($signed(b_i));
         end else begin
            sa = longint'(a_i);
            sb = longint'(b_i);
         end
         q    = sa / sb;
         r    = sa % sb;
         e.lo = q[W-1:0];
         e.hi = r[W-1:0];
      end
      return e;
   endfunction

   // Returns in the done cycle, so a following call issues back-to-back.
   task automatic run_cmd(input string tag, input logic [1:0] op_i, input logic [W-1:0] a_i,
                          input logic [W-1:0] b_i, input int intrude_at);
      exp_t e;
      exp_t x;
      int   lat;
      bit   busy_ok;
      e = model(op_i, a_i, b_i);
      if (!e.div0) begin
         m_hi = e.hi;
         m_lo = e.lo;
      end
      sb_q.push_back(e);
      start = 1'b1;
      op    = op_i;
      a     = a_i;
      b     = b_i;
      @(posedge clk); #1;
      start   = 1'b0;
      op      = 2'($urandom);
      a       = $urandom;
      b       = $urandom;
      lat     = 0;
      busy_ok = 1'b1;
      while (!done && lat < 4*LAT_NORM) begin
         if (!busy) busy_ok = 1'b0;
         start = (lat == intrude_at);
         @(posedge clk); #1;
         lat++;
      end
      start = 1'b0;
      x = sb_q.pop_front();
      check({tag, " latency"}, 64'(lat), 64'(x.lat));
      check({tag, " busy while running"}, {63'b0, busy_ok}, 64'd1);
      check({tag, " busy in done cycle"}, {63'b0, busy}, 64'd0);
      check({tag, " hi"}, 64'(hi), 64'(x.hi));
      check({tag, " lo"}, 64'(lo), 64'(x.lo));
      check({tag, " div0"}, {63'b0, div0}, {63'b0, x.div0});
   endtask

   initial begin
      int n_evt;
      reset = 1'b0;
      start = 1'b0;
      op    = '0;
      a     = '0;
      b     = '0;
      #1;
      check("reset hi/lo", {hi, lo}, 64'd0);
      check("reset busy/done/div0", {61'b0, busy, done, div0}, 64'd0);
      repeat (3) @(posedge clk);
      #1 reset = 1'b1;

      run_cmd("mult neg",  OP_MULT,  32'hFFFF_FFFD, 32'h0000_0007, -1);
      run_cmd("multu max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1);
      run_cmd("div neg",   OP_DIV,   32'hFFFF_FFF9, 32'h0000_0002, -1);
      run_cmd("div ovf",   OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, -1);
      run_cmd("divu load", OP_DIVU,  32'h5678_1234, 32'h0001_0000, -1);
      run_cmd("divu zero", OP_DIVU,  32'h0000_0010, 32'h0000_0000, -1);

      @(posedge clk); #1;
      check("done single pulse", {63'b0, done}, 64'd0);
      check("div0 held", {63'b0, div0}, 64'd1);
      check("hi/lo held", {hi, lo}, {32'h0000_1234, 32'h0000_5678});

      vecs.push_back('{OP_DIV,   32'h0000_0007, 32'hFFFF_FFFE});
      vecs.push_back('{OP_DIV,   32'hFFFF_FFF9, 32'hFFFF_FFFE});
      vecs.push_back('{OP_DIVU,  32'h0000_0005, 32'h0000_0009});
      vecs.push_back('{OP_MULT,  32'h8000_0000, 32'h8000_0000});
      vecs.push_back('{OP_MULT,  32'h7FFF_FFFF, 32'h8000_0000});
      vecs.push_back('{OP_DIV,   32'h0000_0000, 32'h0000_0005});
      vecs.push_back('{OP_DIVU,  32'hFFFF_FFFF, 32'h0000_0001});
      vecs.push_back('{OP_MULTU, 32'h8000_0001, 32'h0000_0003});
      foreach (vecs[i]) run_cmd($sformatf("edge%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, -1);

      for (int i = 0; i < 10; i++) begin
         logic [W-1:0] rb;
         rb = ($urandom_range(0, 5) == 0) ? '0 : $urandom;
         run_cmd($sformatf("rand%0d", i), 2'($urandom), $urandom, rb, -1);
      end

      run_cmd("multu intrude", OP_MULTU, 32'h1234_5678, 32'h9ABC_DEF0, 5);
      @(posedge clk); #1;
      check("intrude no second cmd", {62'b0, busy, done}, 64'd0);

      run_cmd("div zero pre-rst", OP_DIV, 32'h0000_0005, 32'h0000_0000, -1);
      start = 1'b1;
      op    = OP_MULTU;
      a     = 32'hDEAD_BEEF;
      b     = 32'h0000_1111;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      check("busy mid calc", {63'b0, busy}, 64'd1);
      reset = 1'b0;
      #1;
      check("async rst hi/lo", {hi, lo}, 64'd0);
      check("async rst busy/done/div0", {61'b0, busy, done, div0}, 64'd0);
      m_hi = '0;
      m_lo = '0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
      n_evt = 0;
      repeat (LAT_NORM + 10) begin
         @(posedge clk); #1;
         if (done || busy) n_evt++;
      end
      check("no done after rst", 64'(n_evt), 64'd0);

      run_cmd("post rst", OP_MULT, 32'h0000_1234, 32'hFFFF_FF00, -1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/mult_div_seq.md
MULT_DIV_SEQ -- requirements
Module: mult_div_seq

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, meaning operand width in bits (legal range 4..64).
REQ-002 Port clk  in  1  the single clock; all state SHALL change on its rising edge.
REQ-003 Port reset  in  1  asynchronous, active-low reset.
REQ-004 Port start  in  1  command request, sampled only in IDLE.
REQ-005 Port op  in  2  operation: 00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU.
REQ-006 Port a  in  WIDTH  multiplicand or dividend.
REQ-007 Port b  in  WIDTH  multiplier or divisor.
REQ-008 Port hi  out  WIDTH  upper product half or remainder; feeds the HI register.
REQ-009 Port lo  out  WIDTH  lower product half or quotient; feeds the LO register.
REQ-010 Port busy  out  1  high while a command is in progress.
REQ-011 Port done  out  1  single-cycle completion pulse; hi/lo are valid in that cycle.
REQ-012 Port div0  out  1  the last divide had a zero divisor.

Function
REQ-013 States SHALL be IDLE, CALC, SIGN and DONE, encoded as a package enum.
REQ-014 In IDLE with start=1, the block SHALL latch op, a and b and take operand magnitudes for signed ops.
- On the same edge it SHALL clear div0, load the iteration counter with WIDTH and go to CALC.
REQ-015 In IDLE with start=1, a divide op and b=0: go to DONE, set div0=1, leave hi/lo unchanged.
REQ-016 CALC SHALL perform one radix-2 step per cycle.
- Multiply: shift-add into a 2*WIDTH accumulator.
- Divide: restoring shift-subtract.
- Decrement the counter each cycle; go to SIGN after exactly WIDTH cycles.
REQ-017 SIGN SHALL apply the result signs, update hi/lo on the same edge, then go to DONE.
- Signed multiply: product negated when sign(a)!=sign(b).
- Signed divide: quotient negated when signs differ; remainder takes the sign of a.
REQ-018 DONE SHALL assert done for exactly one cycle, then return to IDLE.
REQ-019 Normal latency: done SHALL be high in the cycle following edge k+WIDTH+2, where k is the edge that sampled start.
REQ-020 Divide-by-zero latency: done SHALL be high in the cycle following edge k+1.
REQ-021 busy SHALL be high in CALC, SIGN and DONE and low in IDLE.
REQ-022 start SHALL be ignored while busy=1; the in-flight command and its operands SHALL be unaffected.
REQ-023 op, a and b SHALL be don't-care after the sampling edge.
REQ-024 MULT/MULTU SHALL give {hi,lo} = full 2*WIDTH-bit product.
REQ-025 DIV/DIVU SHALL give lo = quotient truncated toward zero and hi = remainder.
REQ-026 Signed DIV of -2^(WIDTH-1) by -1 SHALL give lo = -2^(WIDTH-1) and hi = 0, with no flag.
REQ-027 hi, lo and div0 SHALL hold their values between commands.
REQ-028 done SHALL be back-to-back capable: start may be asserted in the IDLE cycle immediately after DONE.

Reset
REQ-029 reset low SHALL immediately force state IDLE, counter 0 and accumulators 0, without waiting for clk.
REQ-030 reset low SHALL immediately force hi=0, lo=0, busy=0, done=0 and div0=0.
REQ-031 A reset asserted mid-CALC SHALL discard the command; no done pulse SHALL follow.
REQ-032 After reset deasserts, the first edge with start=1 SHALL begin a new command.

Structure
REQ-033 Package mult_div_pkg SHALL hold the op encoding constants and the state enum.
REQ-034 Counter width SHALL be $clog2(WIDTH)+1, computed locally from WIDTH.
REQ-035 One sub-module, mult_div_negate, SHALL implement a WIDTH-parametrised conditional two's-complement negate.
- It SHALL be instanced for operand magnitude and result sign correction.
REQ-036 No other sub-modules are permitted.

Verification (WIDTH=32)
REQ-037 MULT a=FFFFFFFD, b=00000007 -> hi=FFFFFFFF, lo=FFFFFFEB, done 34 edges after start, busy high throughout.
REQ-038 MULTU a=FFFFFFFF, b=FFFFFFFF -> hi=FFFFFFFE, lo=00000001.
REQ-039 DIV a=FFFFFFF9, b=00000002 -> lo=FFFFFFFD, hi=FFFFFFFF.
REQ-040 DIV a=80000000, b=FFFFFFFF -> lo=80000000, hi=00000000, div0=0.
REQ-041 DIVU a=00000010, b=00000000 with previous hi/lo=1234/5678 -> div0=1, done 1 edge later, hi/lo unchanged.
REQ-042 Second start at cycle 5 of a MULTU -> ignored, first result intact.
REQ-043 reset low at CALC cycle 10 -> busy=0, hi=lo=0 immediately, no done pulse.
